// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM states for the sequential ALU
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_ADC = 3'd2,
      OP_SBC = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_MUL = 3'd7
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - adder/subtractor with carry out and signed overflow
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             inv,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;

   assign b_eff = b ^ {WIDTH{inv}};
   assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
   assign sum   = full[WIDTH-1:0];
   assign cout  = full[WIDTH];
   // Overflow is judged against the effective (possibly inverted) B operand.
   assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - single-cycle ALU with an iterative shift-add multiplier
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic             flag_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             overflow_flag
);

   localparam int CW = $clog2(WIDTH + 1);

   alu_state_e         state, state_nxt;
   alu_op_e            op_e;
   logic               accept, is_mul, last_iter;
   logic               inv, cin, as_cout, as_ovf;
   logic [WIDTH-1:0]   as_sum;
   logic [WIDTH-1:0]   res_c;
   logic               cy_c, ov_c;
   logic [2*WIDTH-1:0] acc, mcand, acc_add;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               fwe_q;

   assign op_e      = alu_op_e'(op);
   assign accept    = start && (state == IDLE);
   assign is_mul    = (MUL_EN != 0) && (op_e == OP_MUL);
   assign last_iter = (state == MUL) && (cnt == CW'(WIDTH - 1));
   assign acc_add   = acc + (mplier[0] ? mcand : '0);

   assign inv = (op_e == OP_SUB) || (op_e == OP_SBC);

   always_comb begin
      cin = 1'b0;
      case (op_e)
         OP_SUB:         cin = 1'b1;
         OP_ADC, OP_SBC: cin = carry_flag;
         default:        cin = 1'b0;
      endcase
   end

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (a),
      .b    (b),
      .inv  (inv),
      .cin  (cin),
      .sum  (as_sum),
      .cout (as_cout),
      .ovf  (as_ovf)
   );

   // Single-cycle results; op 7 lands here only when the multiplier is not built.
   always_comb begin
      res_c = as_sum;
      cy_c  = as_cout;
      ov_c  = as_ovf;
      case (op_e)
         OP_AND: begin res_c = a & b; cy_c = 1'b0; ov_c = 1'b0; end
         OP_OR:  begin res_c = a | b; cy_c = 1'b0; ov_c = 1'b0; end
         OP_XOR: begin res_c = a ^ b; cy_c = 1'b0; ov_c = 1'b0; end
         OP_MUL: begin res_c = a;     cy_c = 1'b0; ov_c = 1'b0; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_mul) state_nxt = MUL;
         MUL:     if (last_iter)        state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == MUL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done          <= 1'b0;
         result        <= '0;
         carry_flag    <= 1'b0;
         zero_flag     <= 1'b0;
         overflow_flag <= 1'b0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         cnt           <= '0;
         fwe_q         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (is_mul) begin
               acc    <= '0;
               mcand  <= {{WIDTH{1'b0}}, a};
               mplier <= b;
               cnt    <= '0;
               fwe_q  <= flag_we;
            end else begin
               result <= res_c;
               done   <= 1'b1;
               if (flag_we) begin
                  carry_flag    <= cy_c;
                  zero_flag     <= (res_c == '0);
                  overflow_flag <= ov_c;
               end
            end
         end else if (state == MUL) begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
               result <= acc_add[WIDTH-1:0];
               done   <= 1'b1;
               if (fwe_q) begin
                  carry_flag    <= |acc_add[2*WIDTH-1:WIDTH];
                  zero_flag     <= (acc_add[WIDTH-1:0] == '0);
                  overflow_flag <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1, meaning the iterative multiplier is built; when 0, op MUL behaves as a reserved op.
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 The block SHALL have port op  input  3  operation code, sampled on an accepted start.
REQ-008 The block SHALL have port start  input  1  request to begin an operation.
REQ-009 The block SHALL have port flag_we  input  1  flags update enable, sampled on an accepted start.
REQ-010 The block SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-012 The block SHALL have port result  output  WIDTH  registered result, held until the next completion.
REQ-013 The block SHALL have ports carry_flag, zero_flag, overflow_flag  output  1 each  registered flags.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MUL.
REQ-015 A start SHALL be accepted only in state IDLE; start while busy SHALL be ignored with no side effects.
REQ-016 Ops 0-6 SHALL complete in one cycle: result registered on the accepting edge, done high for the following cycle, busy stays low.
REQ-017 Arithmetic SHALL be a + (b XOR {WIDTH{inv}}) + cin with a WIDTH+1 bit sum; inv=1 for SUB/SBC; cin = 0 ADD, 1 SUB, carry_flag ADC, carry_flag SBC.
REQ-018 For arithmetic ops, carry SHALL be bit WIDTH of the sum (for SUB, 1 means no borrow, i.e. a >= b unsigned).
REQ-019 For arithmetic ops, overflow SHALL be signed overflow: operand-A sign equals effective-B sign and differs from the result sign.
REQ-020 For AND/OR/XOR, carry and overflow SHALL be 0.
REQ-021 zero SHALL be 1 exactly when all WIDTH result bits are 0, for every op.
REQ-022 MUL SHALL use an unsigned shift-add engine: FSM IDLE -> MUL on start, exactly WIDTH cycles in MUL, then IDLE; busy high throughout MUL.
REQ-023 MUL result SHALL be the low WIDTH bits of a*b; carry SHALL be 1 when the upper WIDTH product bits are nonzero; overflow SHALL be 0.
REQ-024 done SHALL pulse in the cycle after the last MUL iteration, with busy already low; a new start SHALL be acceptable in that same cycle.
REQ-025 Flags SHALL update at completion only when flag_we was high at acceptance; otherwise they SHALL hold, while result still updates.
REQ-026 When MUL_EN=0, op 7 SHALL complete in one cycle with result = a, carry and overflow 0.

Reset
REQ-027 On rst_n low, the FSM SHALL go to IDLE asynchronously; result, all flags, busy and done SHALL be 0.
REQ-028 Reset during MUL SHALL abort the operation with no done pulse after release.
REQ-029 start SHALL be ignored on the first edge after rst_n deasserts only if synchronously still low; there is no other post-reset delay.

Structure
REQ-030 Package alu_pkg SHALL hold the alu_op_e enum (3-bit op codes) and alu_state_e (IDLE, MUL).
REQ-031 Sub-module alu_addsub (WIDTH, a, b, inv, cin -> sum, cout, ovf) SHALL implement REQ-017..019, instantiated once.
REQ-032 The MUL datapath (accumulator 2*WIDTH, multiplier shift register, iteration counter of clog2(WIDTH+1) bits) SHALL live in alu_seq.

Verification (WIDTH=8)
REQ-033 ADD a=0xFF b=0x01 flag_we=1 -> next cycle done=1, result=0x00, carry=1, zero=1, overflow=0.
REQ-034 SUB a=0x80 b=0x01 flag_we=1 -> result=0x7F, carry=1, overflow=1, zero=0.
REQ-035 carry=1 then ADC a=0x10 b=0x20 -> result=0x31; then SUB 0x05-0x06 then SBC 0x00-0x00 -> result=0xFF, carry=0.
REQ-036 MUL a=0x10 b=0x11 -> busy for 8 cycles, start pulses ignored meanwhile, done on cycle 9, result=0x10, carry=1.
REQ-037 XOR a=0xAA b=0xAA flag_we=0 after carry=1 -> result=0x00, flags unchanged (carry=1, zero per prior).
REQ-038 rst_n low at MUL iteration 4 -> busy=0, result=0, flags=0 immediately, no done after release.
